// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results take the single write slot first,
// queued load results drain otherwise. Optional bypass compare enabled by WB_BYPASS_EN.
module regfile_writeback #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [W-1:0]           alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [4:0]             ld_rd,
    input  logic [W-1:0]           ld_data,
    output logic [4:0]             WriteReg,
    output logic [W-1:0]           WriteData,
    output logic                   RegWrite,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic [4:0]             byp_rs1,
    input  logic [4:0]             byp_rs2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic [W-1:0]           byp_data1,
    output logic [W-1:0]           byp_data2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [W-1:0]  data_mem_q [DEPTH];
    logic [W-1:0]  data_mem_d [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [W-1:0]  write_data_q, write_data_d;

    logic          accept;
    logic          push;
    logic          pop;

    assign ld_ready = (count_q != CW'(DEPTH));
    assign accept   = ld_valid && ld_ready;
    // Loads to x0 are handshaken but never stored.
    assign push     = accept && (ld_rd != 5'd0);
    assign pop      = !alu_valid && (count_q != '0);

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr_q == AW'(i))) begin
                rd_mem_d[i]   = ld_rd;
                data_mem_d[i] = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // An ALU result always owns the slot, even for x0 where it only blanks the enable.
    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (alu_valid) begin
            reg_write_d  = (alu_rd != 5'd0);
            write_reg_d  = alu_rd;
            write_data_d = alu_data;
        end else if (pop) begin
            reg_write_d  = 1'b1;
            write_reg_d  = rd_mem_q[rd_ptr_q];
            write_data_d = data_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign RegWrite   = reg_write_q;
    assign WriteReg   = write_reg_q;
    assign WriteData  = write_data_q;
    assign fifo_count = count_q;

`ifdef WB_BYPASS_EN
    logic [9:0]     rs_vec;
    logic [1:0]     hit_vec;
    logic [2*W-1:0] data_vec;

    assign rs_vec = {byp_rs2, byp_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byp
            assign hit_vec[gi] = reg_write_q && (rs_vec[gi*5 +: 5] != 5'd0)
                                 && (write_reg_q == rs_vec[gi*5 +: 5]);
            assign data_vec[gi*W +: W] = hit_vec[gi] ? write_data_q : '0;
        end
    endgenerate

    assign byp_hit1  = hit_vec[0];
    assign byp_hit2  = hit_vec[1];
    assign byp_data1 = data_vec[0 +: W];
    assign byp_data2 = data_vec[W +: W];
`else
    logic unused_byp;
    assign unused_byp = ^{byp_rs1, byp_rs2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic
// against a queue-based reference model of the writeback arbiter.
module tb_regfile_writeback;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         alu_valid;
    logic [4:0]   alu_rd;
    logic [W-1:0] alu_data;
    logic         ld_valid;
    logic         ld_ready;
    logic [4:0]   ld_rd;
    logic [W-1:0] ld_data;
    logic [4:0]   WriteReg;
    logic [W-1:0] WriteData;
    logic         RegWrite;
    logic [2:0]   fifo_count;
    logic [4:0]   byp_rs1, byp_rs2;
    logic         byp_hit1, byp_hit2;
    logic [W-1:0] byp_data1, byp_data2;

    int total  = 0;
    int passed = 0;

    // Reference model: expected output registers and the pending-load queue.
    logic         exp_we;
    logic [4:0]   exp_wr;
    logic [W-1:0] exp_wd;
    logic [4:0]   mq_rd[$];
    logic [W-1:0] mq_data[$];

    regfile_writeback #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .fifo_count(fifo_count),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic clock_edge();
        logic         nwe;
        logic [4:0]   nwr;
        logic [W-1:0] nwd;
        logic         do_pop, do_push, in_rst;
        logic [4:0]   s_rd;
        logic [W-1:0] s_data;
        in_rst  = !rst_n;
        do_pop  = 1'b0;
        do_push = ld_valid && (mq_rd.size() != DEPTH) && (ld_rd != 5'd0);
        s_rd    = ld_rd;
        s_data  = ld_data;
        nwe = 1'b0; nwr = exp_wr; nwd = exp_wd;
        if (in_rst) begin
            nwr = '0; nwd = '0;
        end else if (alu_valid) begin
            nwe = (alu_rd != 5'd0); nwr = alu_rd; nwd = alu_data;
        end else if (mq_rd.size() > 0) begin
            nwe = 1'b1; nwr = mq_rd[0]; nwd = mq_data[0]; do_pop = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_we = nwe; exp_wr = nwr; exp_wd = nwd;
        if (in_rst) begin
            mq_rd.delete();
            mq_data.delete();
        end else begin
            if (do_pop) begin
                mq_rd.delete(0);
                mq_data.delete(0);
            end
            if (do_push) begin
                mq_rd.push_back(s_rd);
                mq_data.push_back(s_data);
            end
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = $urandom;
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = $urandom;
        byp_rs1 = '0; byp_rs2 = '0;
        clock_edge();
        clock_edge();
        rst_n = 1'b1;
        drive_idle();
        total++; if (RegWrite !== 1'b0) $display("FAIL reset_we: got %0b want 0", RegWrite); else passed++;
        total++; if (WriteReg !== 5'd0) $display("FAIL reset_wr: got %0d want 0", WriteReg); else passed++;
        total++; if (WriteData !== '0) $display("FAIL reset_wd: got %h want 0", WriteData); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
        total++; if (ld_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", ld_ready); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        clock_edge();
        drive_idle();
        total++; if (RegWrite !== 1'b1) $display("FAIL alu1_we: got %0b want 1", RegWrite); else passed++;
        total++; if (WriteReg !== 5'd5) $display("FAIL alu1_wr: got %0d want 5", WriteReg); else passed++;
        total++; if (WriteData !== 32'hDEADBEEF) $display("FAIL alu1_wd: got %h want deadbeef", WriteData); else passed++;
        clock_edge();
        total++; if (RegWrite !== 1'b0) $display("FAIL alu1_we_after: got %0b want 0", RegWrite); else passed++;
        total++; if (WriteReg !== 5'd5 || WriteData !== 32'hDEADBEEF)
            $display("FAIL alu1_hold: got %0d/%h want 5/deadbeef", WriteReg, WriteData); else passed++;
        $display("test_alu_single done");
    endtask

    task automatic test_alu_priority_fill();
        int  idx;
        logic acc;
        idx = 1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + cyc); alu_data = $urandom;
            ld_valid = (idx <= 5); ld_rd = 5'(idx); ld_data = 32'hA000 + idx;
            acc = ld_valid && ld_ready;
            clock_edge();
            if (acc) idx++;
            total++; if (RegWrite !== 1'b1 || WriteReg !== 5'(20 + cyc))
                $display("FAIL fill_alu_prio cyc %0d: got we=%0b rd=%0d want we=1 rd=%0d", cyc, RegWrite, WriteReg, 20 + cyc);
            else passed++;
        end
        total++; if (idx != 5) $display("FAIL fill_accepts: got %0d want 4", idx - 1); else passed++;
        total++; if (fifo_count !== 3'd4) $display("FAIL fill_count: got %0d want 4", fifo_count); else passed++;
        total++; if (ld_ready !== 1'b0) $display("FAIL fill_ready: got %0b want 0", ld_ready); else passed++;
        alu_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ld_valid = (idx <= 5); ld_rd = 5'(idx); ld_data = 32'hA000 + idx;
            acc = ld_valid && ld_ready;
            clock_edge();
            if (acc) idx++;
            total++; if (RegWrite !== 1'b1 || WriteReg !== 5'(k) || WriteData !== 32'hA000 + k)
                $display("FAIL drain_order k %0d: got we=%0b rd=%0d d=%h want we=1 rd=%0d d=%h",
                         k, RegWrite, WriteReg, WriteData, k, 32'hA000 + k);
            else passed++;
        end
        drive_idle();
        clock_edge();
        total++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL drain_empty: got we=%0b count=%0d want 0/0", RegWrite, fifo_count); else passed++;
        $display("test_alu_priority_fill done");
    endtask

    task automatic test_zero_rd();
        int bad_we, bad_cnt;
        bad_we = 0; bad_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (c < 4); alu_rd = 5'd0; alu_data = $urandom;
            ld_valid  = (c < 6); ld_rd  = 5'd0; ld_data  = $urandom;
            clock_edge();
            if (RegWrite !== 1'b0) bad_we++;
            if (fifo_count !== 3'd0) bad_cnt++;
        end
        drive_idle();
        total++; if (bad_we != 0) $display("FAIL zero_rd_we: got %0d writes want 0", bad_we); else passed++;
        total++; if (bad_cnt != 0) $display("FAIL zero_rd_count: got %0d nonzero counts want 0", bad_cnt); else passed++;
        $display("test_zero_rd done");
    endtask

    task automatic test_wrap();
        int sent, got, guard;
        logic acc;
        sent = 0; got = 0; guard = 0;
        alu_valid = 1'b1; alu_rd = 5'd0;
        while (fifo_count != 3'd4 && guard < 20) begin
            alu_data = $urandom;
            ld_valid = 1'b1; ld_rd = 5'(sent + 1); ld_data = 32'hC000_0000 + 32'(sent * 7);
            acc = ld_ready;
            clock_edge();
            if (acc) sent++;
            guard++;
        end
        total++; if (fifo_count !== 3'd4) $display("FAIL wrap_fill: got count %0d want 4", fifo_count); else passed++;
        alu_valid = 1'b0;
        guard = 0;
        while (got < 12 && guard < 40) begin
            ld_valid = (sent < 12); ld_rd = 5'(sent + 1); ld_data = 32'hC000_0000 + 32'(sent * 7);
            acc = ld_valid && ld_ready;
            clock_edge();
            if (acc) sent++;
            guard++;
            total++; if (RegWrite !== 1'b1 || WriteReg !== 5'(got + 1) || WriteData !== 32'hC000_0000 + 32'(got * 7))
                $display("FAIL wrap_order n %0d: got we=%0b rd=%0d d=%h want we=1 rd=%0d d=%h",
                         got, RegWrite, WriteReg, WriteData, got + 1, 32'hC000_0000 + 32'(got * 7));
            else passed++;
            if (got == 0) begin
                total++; if (ld_ready !== 1'b1) $display("FAIL wrap_ready_back: got %0b want 1", ld_ready); else passed++;
            end
            got++;
        end
        drive_idle();
        clock_edge();
        total++; if (fifo_count !== 3'd0 || RegWrite !== 1'b0)
            $display("FAIL wrap_end: got count=%0d we=%0b want 0/0", fifo_count, RegWrite); else passed++;
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        alu_valid = 1'b1; alu_rd = 5'd0;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_rd = 5'(3 + k); ld_data = 32'hB000 + k;
            clock_edge();
        end
        total++; if (fifo_count !== 3'd3) $display("FAIL midrst_fill: got %0d want 3", fifo_count); else passed++;
        ld_valid = 1'b0; alu_rd = 5'd9; alu_data = 32'h5555AAAA;
        clock_edge();
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = $urandom;
        ld_valid  = 1'b1; ld_rd  = 5'd6;  ld_data  = $urandom;
        clock_edge();
        rst_n = 1'b1;
        drive_idle();
        total++; if (fifo_count !== 3'd0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else passed++;
        total++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== '0)
            $display("FAIL midrst_out: got we=%0b rd=%0d d=%h want 0/0/0", RegWrite, WriteReg, WriteData); else passed++;
        total++; if (ld_ready !== 1'b1) $display("FAIL midrst_ready: got %0b want 1", ld_ready); else passed++;
        for (int c = 0; c < 6; c++) begin
            clock_edge();
            if (RegWrite !== 1'b0) stale++;
        end
        total++; if (stale != 0) $display("FAIL midrst_stale: got %0d writes want 0", stale); else passed++;
        $display("test_reset_mid done");
    endtask

    task automatic test_bypass();
        logic         e_hit1, e_hit2;
        logic [W-1:0] e_d1, e_d2;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h12345678;
        clock_edge();
        drive_idle();
        byp_rs1 = 5'd7; byp_rs2 = 5'd0;
        #1;
`ifdef WB_BYPASS_EN
        e_hit1 = 1'b1; e_d1 = 32'h12345678;
`else
        e_hit1 = 1'b0; e_d1 = '0;
`endif
        e_hit2 = 1'b0; e_d2 = '0;
        total++; if (byp_hit1 !== e_hit1 || byp_data1 !== e_d1)
            $display("FAIL byp_port1: got %0b/%h want %0b/%h", byp_hit1, byp_data1, e_hit1, e_d1); else passed++;
        total++; if (byp_hit2 !== e_hit2 || byp_data2 !== e_d2)
            $display("FAIL byp_port2_x0: got %0b/%h want %0b/%h", byp_hit2, byp_data2, e_hit2, e_d2); else passed++;
        clock_edge();
        byp_rs1 = 5'd7; byp_rs2 = 5'd7;
        #1;
        total++; if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0 || byp_data1 !== '0 || byp_data2 !== '0)
            $display("FAIL byp_no_write: got %0b%0b %h %h want 00 0 0", byp_hit1, byp_hit2, byp_data1, byp_data2);
        else passed++;
        byp_rs1 = '0; byp_rs2 = '0;
        $display("test_bypass done");
    endtask

    task automatic test_random();
        logic         e_hit1, e_hit2;
        logic [W-1:0] e_d1, e_d2;
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 9) < 7);
            ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_data   = $urandom;
            #1;
            total++; if (ld_ready !== (mq_rd.size() != DEPTH))
                $display("FAIL rand_ready cyc %0d: got %0b want %0b", c, ld_ready, mq_rd.size() != DEPTH); else passed++;
            clock_edge();
            total++; if (RegWrite !== exp_we || WriteReg !== exp_wr || WriteData !== exp_wd)
                $display("FAIL rand_write cyc %0d: got %0b/%0d/%h want %0b/%0d/%h",
                         c, RegWrite, WriteReg, WriteData, exp_we, exp_wr, exp_wd);
            else passed++;
            total++; if (fifo_count !== 3'(mq_rd.size()))
                $display("FAIL rand_count cyc %0d: got %0d want %0d", c, fifo_count, mq_rd.size()); else passed++;
            byp_rs1 = ($urandom_range(0, 1) == 0) ? exp_wr : 5'($urandom_range(0, 31));
            byp_rs2 = ($urandom_range(0, 1) == 0) ? exp_wr : 5'($urandom_range(0, 31));
            #1;
`ifdef WB_BYPASS_EN
            e_hit1 = exp_we && (byp_rs1 != 5'd0) && (byp_rs1 == exp_wr);
            e_hit2 = exp_we && (byp_rs2 != 5'd0) && (byp_rs2 == exp_wr);
`else
            e_hit1 = 1'b0;
            e_hit2 = 1'b0;
`endif
            e_d1 = e_hit1 ? exp_wd : '0;
            e_d2 = e_hit2 ? exp_wd : '0;
            total++; if (byp_hit1 !== e_hit1 || byp_data1 !== e_d1 || byp_hit2 !== e_hit2 || byp_data2 !== e_d2)
                $display("FAIL rand_bypass cyc %0d: got %0b/%h %0b/%h want %0b/%h %0b/%h",
                         c, byp_hit1, byp_data1, byp_hit2, byp_data2, e_hit1, e_d1, e_hit2, e_d2);
            else passed++;
        end
        rst_n = 1'b1;
        drive_idle();
        $display("test_random done");
    endtask

    initial begin
        exp_we = 1'b0; exp_wr = '0; exp_wd = '0;
        rst_n = 1'b0;
        drive_idle();
        byp_rs1 = '0; byp_rs2 = '0;
        test_reset();
        test_alu_single();
        test_alu_priority_fill();
        test_zero_rd();
        test_wrap();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
